// File: rtl/sobel_pkg.sv
// Shared widths, output-mode encodings and the saturation helper for the Sobel stream.
package sobel_pkg;

   localparam int unsigned PIX_W_DEF = 8;
   localparam int unsigned GRAD_W    = PIX_W_DEF + 3;
   localparam int unsigned MAG_W     = PIX_W_DEF + 4;

   localparam logic MODE_MAG = 1'b0;
   localparam logic MODE_THR = 1'b1;

   // Clamp a magnitude to the largest value representable in pix_w bits.
   function automatic int unsigned sat_pix(input int unsigned mag, input int unsigned pix_w);
      int unsigned max_v;
      max_v = (32'd1 << pix_w) - 32'd1;
      return (mag > max_v) ? max_v : mag;
   endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two chained line buffers: row1 holds the previous line, row2 the one before it.
module sobel_line_buf #(
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned IMG_W  = 640,
   parameter int unsigned ADDR_W = $clog2(IMG_W)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [PIX_W-1:0]  din,
   output logic [PIX_W-1:0]  dout_row1,
   output logic [PIX_W-1:0]  dout_row2
);

   logic [PIX_W-1:0] row1_mem [IMG_W];
   logic [PIX_W-1:0] row2_mem [IMG_W];

   assign dout_row1 = row1_mem[addr];
   assign dout_row2 = row2_mem[addr];

   // Read-before-write: the old row1 entry ages into row2 as the new pixel lands.
   always_ff @(posedge clk) begin
      if (en) begin
         row1_mem[addr] <= din;
         row2_mem[addr] <= row1_mem[addr];
      end
   end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with line buffers, two output modes and valid/ready.
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned COL_W = $clog2(IMG_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mode,
   input  logic [PIX_W+3:0] thresh,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [PIX_W-1:0] in_pix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pix
);

   localparam int unsigned GW = PIX_W + 3;
   localparam int unsigned MW = PIX_W + 4;

   logic [COL_W-1:0] col_q, col_d, col_eff;
   logic [1:0]       row_q, row_d, row_eff;
   logic [PIX_W-1:0] win_q [9];
   logic [PIX_W-1:0] win_d [9];
   logic             border_q, border_d;
   logic             s1_valid_q, s1_valid_d;
   logic             out_valid_q, out_valid_d;
   logic [PIX_W-1:0] out_pix_q, out_pix_d;
   logic [PIX_W-1:0] lb_row1, lb_row2;
   logic             advance, accept;

   logic signed [GW-1:0] gx, gy, abs_gx, abs_gy;
   logic [MW-1:0]        mag;
   logic [PIX_W-1:0]     s2_pix;

   assign advance = out_ready || !out_valid_q;
   assign accept  = in_valid && advance;
   assign col_eff = in_sof ? '0 : col_q;
   assign row_eff = in_sof ? '0 : row_q;

   sobel_line_buf #(
      .PIX_W (PIX_W),
      .IMG_W (IMG_W),
      .ADDR_W(COL_W)
   ) u_line_buf (
      .clk      (clk),
      .en       (accept),
      .addr     (col_eff),
      .din      (in_pix),
      .dout_row1(lb_row1),
      .dout_row2(lb_row2)
   );

   function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({{(GW - PIX_W){1'b0}}, p});
   endfunction

   always_comb begin
      gx = (ext(win_q[2]) + (ext(win_q[5]) <<< 1) + ext(win_q[8]))
         - (ext(win_q[0]) + (ext(win_q[3]) <<< 1) + ext(win_q[6]));
      gy = (ext(win_q[0]) + (ext(win_q[1]) <<< 1) + ext(win_q[2]))
         - (ext(win_q[6]) + (ext(win_q[7]) <<< 1) + ext(win_q[8]));
      abs_gx = gx[GW-1] ? -gx : gx;
      abs_gy = gy[GW-1] ? -gy : gy;
      mag    = MW'($unsigned(abs_gx)) + MW'($unsigned(abs_gy));
      if (border_q) begin
         s2_pix = '0;
      end else if (mode == MODE_THR) begin
         s2_pix = (mag >= thresh) ? '1 : '0;
      end else begin
         s2_pix = PIX_W'(sat_pix(32'(mag), PIX_W));
      end
   end

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      win_d       = win_q;
      border_d    = border_q;
      s1_valid_d  = s1_valid_q;
      out_valid_d = out_valid_q;
      out_pix_d   = out_pix_q;
      if (accept) begin
         if (col_eff == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
         end else begin
            col_d = col_eff + 1'b1;
            row_d = row_eff;
         end
         // New rightmost column: oldest line on top, incoming pixel at the bottom.
         win_d[0] = win_q[1];
         win_d[1] = win_q[2];
         win_d[2] = lb_row2;
         win_d[3] = win_q[4];
         win_d[4] = win_q[5];
         win_d[5] = lb_row1;
         win_d[6] = win_q[7];
         win_d[7] = win_q[8];
         win_d[8] = in_pix;
         border_d = (row_eff < 2'd2) || (col_eff < COL_W'(2));
      end
      if (advance) begin
         s1_valid_d  = accept;
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_pix_d = s2_pix;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         out_pix_q   <= out_pix_d;
      end
   end

   always_ff @(posedge clk) begin
      win_q    <= win_d;
      border_q <= border_d;
   end

   assign in_ready  = advance;
   assign out_valid = out_valid_q;
   assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on 8x8 frames: a direct Sobel model fills the queue.
module tb_sobel_stream;

   localparam int PW = 8;
   localparam int IW = 8;
   localparam int IH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mode = 1'b0;
   logic [PW+3:0] thresh = '0;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [PW-1:0] in_pix = '0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic          out_valid;
   logic [PW-1:0] out_pix;

   int            n_cmp = 0;
   int            n_err = 0;
   int            out_count = 0;
   int            stall_cnt = 0;
   int            img [IH][IW];
   logic [PW-1:0] exp_q [$];
   logic          stalled_prev = 1'b0;
   logic [PW-1:0] held_pix = '0;

   sobel_stream #(
      .PIX_W(PW),
      .IMG_W(IW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .thresh   (thresh),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_sof   (in_sof),
      .in_pix   (in_pix),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_pix  (out_pix)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] golden(input int r, input int c);
      int p [9];
      int gx, gy, mag;
      if (r < 2 || c < 2) return '0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            p[i*3+j] = img[r-2+i][c-2+j];
         end
      end
      gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy  = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mode) return (mag >= int'(thresh)) ? 8'd255 : 8'd0;
      return (mag > 255) ? 8'd255 : PW'(mag);
   endfunction

   // Downstream ready: normally high, dropped while stall_cnt is pending.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Output monitor: stall stability and scoreboard compare on each handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && !out_ready) begin
            if (stalled_prev) chk("stall_hold_pix", out_pix, held_pix);
            chk("stall_in_ready", in_ready, 0);
            held_pix     = out_pix;
            stalled_prev = 1'b1;
         end else begin
            stalled_prev = 1'b0;
         end
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", out_valid, 0);
            end else begin
               chk("out_pix", out_pix, exp_q.pop_front());
            end
            out_count++;
         end
      end
   end

   task automatic send_pix(input logic [PW-1:0] p, input logic sof, input int r, input int c);
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_pix   = p;
      in_sof   = sof;
      while (!in_ready && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", in_ready, 1);
         in_valid = 1'b0;
         return;
      end
      img[r][c] = p;
      exp_q.push_back(golden(r, c));
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   // kind: 0 flat, 1 vertical step, 2 noisy ramp with a mid-line stall, 3 random.
   task automatic send_frame(input int kind, input int limit);
      int n = 0;
      logic [PW-1:0] p;
      for (int r = 0; r < IH; r++) begin
         for (int c = 0; c < IW; c++) begin
            if (n < limit) begin
               case (kind)
                  0:       p = 8'd100;
                  1:       p = (c < 4) ? 8'd0 : 8'd255;
                  2:       p = PW'(r*20 + c*10 + $urandom_range(0, 15));
                  default: p = PW'($urandom_range(0, 255));
               endcase
               send_pix(p, (r == 0 && c == 0), r, c);
               if (kind == 2 && n == 20) stall_cnt = 5;
               n++;
            end
         end
      end
      idle();
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while (exp_q.size() != 0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      chk(tag, exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int c0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_pix", out_pix, 0);
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      mode = 1'b0;
      c0 = out_count;
      send_frame(0, 64);
      drain("flat_drain");
      chk("flat_count", out_count - c0, 64);

      c0 = out_count;
      send_frame(1, 64);
      drain("step_mag_drain");
      chk("step_mag_count", out_count - c0, 64);

      mode   = 1'b1;
      thresh = 12'd1020;
      send_frame(1, 64);
      drain("step_thr1020_drain");
      thresh = 12'd1021;
      send_frame(1, 64);
      drain("step_thr1021_drain");

      mode = 1'b0;
      c0   = out_count;
      send_frame(2, 64);
      drain("bp_drain");
      chk("bp_count", out_count - c0, 64);

      c0 = out_count;
      send_frame(3, 13);
      send_frame(3, 64);
      drain("sof_drain");
      chk("sof_count", out_count - c0, 77);

      send_frame(2, 30);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_pix", out_pix, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      c0 = out_count;
      send_frame(3, 64);
      drain("post_rst_drain");
      chk("post_rst_count", out_count - c0, 64);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
